instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: FIFO_DEPTH, 2, number of entries in the fetched-instruction buffer (power of two, >= 2).
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction word presented on fault entries.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: pc_current  input  32  fetch address from the program counter register.
REQ-006 Port: fetch_req  input  1  core requests a fetch at pc_current.
REQ-007 Port: flush  input  1  redirect; discard buffered and in-flight fetches.
REQ-008 Port: pc_accept  output  1  one-cycle pulse; pc_current was taken, upstream may load pc_next.
REQ-009 Port: imem_req / imem_addr  output  1 / 32  instruction-memory request and word address.
REQ-010 Port: imem_gnt  input  1  memory accepts the request this cycle.
REQ-011 Port: imem_rvalid / imem_rdata  input  1 / 32  read response and data.
REQ-012 Port: instr_valid / instr_data / instr_pc / instr_fault  output  1 / 32 / 32 / 1  head of buffer toward decode.
REQ-013 Port: instr_ready  input  1  decode consumes the head entry.

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT and DISCARD.
REQ-015 IDLE: launch when fetch_req=1, flush=0 and count < FIFO_DEPTH (count sampled before same-cycle pop); pc_accept=1 in the launch cycle only.
REQ-016 Launch with pc_current[1:0]!=0: no memory request; push {NOP_INSTR, pc_current, fault=1} the same edge; stay IDLE.
REQ-017 Aligned launch: latch address, go to REQ; imem_req=1 and imem_addr stable until the imem_gnt cycle.
REQ-018 REQ + imem_gnt -> WAIT; imem_req deasserts the following cycle; at most one request outstanding.
REQ-019 WAIT + imem_rvalid -> push {imem_rdata, latched address, fault=0}, return to IDLE; earliest response is the cycle after grant.
REQ-020 instr_valid = (count != 0); head fields registered; pop on instr_valid & instr_ready; push and pop in the same cycle SHALL both succeed.
REQ-021 Fetch-to-decode latency SHALL be one cycle after the rvalid cycle (instr_valid visible the cycle after rvalid).
REQ-022 flush SHALL empty the buffer on the same edge (count=0, instr_valid=0 next cycle) and block launch in that cycle.
REQ-023 flush in REQ: imem_req held until imem_gnt, then DISCARD; flush in WAIT (including rvalid same cycle): response dropped, -> DISCARD unless rvalid arrived that cycle, then IDLE.
REQ-024 DISCARD: drop next imem_rvalid data, -> IDLE; no push.
REQ-025 Buffer pointers SHALL wrap modulo FIFO_DEPTH; no push when full, no pop when empty.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, count=0, pointers=0, imem_req=0, imem_addr=0, pc_accept=0, instr_valid=0, instr_data=0, instr_pc=0, instr_fault=0.
REQ-027 Reset mid-transaction SHALL abandon the outstanding access; a late imem_rvalid after release in IDLE SHALL be ignored.

Structure
REQ-028 Shared package holds FSM state encodings, NOP_INSTR, and the fetch-entry field widths (32+32+1).
REQ-029 One sub-module, fetch_fifo (synchronous FIFO, FIFO_DEPTH entries, flush input), SHALL hold the buffer.

Verification
REQ-030 Reset: rst_n=0 mid-WAIT -> all outputs 0 immediately, state IDLE; post-release rvalid produces no entry.
REQ-031 Basic: pc=0x00000004, gnt same cycle, rvalid+rdata=0x00500093 next cycle -> instr_valid=1, instr_data=0x00500093, instr_pc=0x00000004, fault=0.
REQ-032 Back-pressure: instr_ready=0, fetches at 0x0,0x4,0x8 -> two entries buffered, third launch blocked (pc_accept=0) until one pop.
REQ-033 Misaligned: pc=0x00000006 -> no imem_req, entry {0x00000013, 0x00000006, fault=1}.
REQ-034 Flush in WAIT: fetch 0x10, flush before rvalid, rdata=0xDEADBEEF -> dropped, buffer empty; next fetch 0x100 returns correctly.
REQ-035 Delayed grant: imem_gnt low 3 cycles -> imem_req and imem_addr=0x80000000 held stable, single request issued.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// the default NOP word and the layout of one buffered fetch entry.
package instr_fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;
   localparam int ENTRY_W = INSTR_W + PC_W + 1;

   localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous buffer of fetched instructions with a registered head entry
// and a flush that empties it in one edge.
module fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_next;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;
   fetch_entry_t  head_next;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Forward the incoming entry when it becomes the new head on this edge.
   always_comb begin
      rd_next   = rd_ptr + PW'(do_pop);
      head_next = mem[rd_next];
      if (do_push && (wr_ptr == rd_next)) begin
         head_next = push_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         rd_ptr <= rd_next;
         count  <= count + CW'(do_push) - CW'(do_pop);
         head   <= head_next;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues one memory request at a time for the
// current PC and buffers the returned words toward decode.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int                 FIFO_DEPTH = 2,
   parameter logic [INSTR_W-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PC_W-1:0]    pc_current,
   input  logic               fetch_req,
   input  logic               flush,
   output logic               pc_accept,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_data,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_fault,
   input  logic               instr_ready
);

   fetch_state_t  state;
   fetch_state_t  state_next;
   logic [PC_W-1:0] addr_q;
   logic          flush_pend;
   logic          launch;
   logic          misaligned;
   logic          push;
   fetch_entry_t  push_entry;
   logic          fifo_full;
   logic          fifo_empty;
   fetch_entry_t  head;

   assign misaligned = (pc_current[1:0] != 2'b00);
   assign launch     = rst_n & (state == IDLE) & fetch_req & ~flush & ~fifo_full;

   // A flush seen while the request is still ungranted turns the grant into a discard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         flush_pend <= 1'b0;
      end else begin
         state <= state_next;
         if (launch && !misaligned) begin
            addr_q <= pc_current;
         end
         if (state == REQ) begin
            flush_pend <= imem_gnt ? 1'b0 : (flush_pend | flush);
         end else begin
            flush_pend <= 1'b0;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (launch && !misaligned) state_next = REQ;
         REQ:     if (imem_gnt) state_next = (flush || flush_pend) ? DISCARD : WAIT;
         WAIT: begin
            if (flush) begin
               state_next = imem_rvalid ? IDLE : DISCARD;
            end else if (imem_rvalid) begin
               state_next = IDLE;
            end
         end
         DISCARD: if (imem_rvalid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pc_accept  = launch;
      imem_req   = (state == REQ);
      push       = (launch & misaligned) | ((state == WAIT) & imem_rvalid & ~flush);
      push_entry = '{instr: imem_rdata, pc: addr_q, fault: 1'b0};
      if (state == IDLE) begin
         push_entry = '{instr: NOP_INSTR, pc: pc_current, fault: 1'b1};
      end
   end

   assign imem_addr = addr_q;

   fetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .push       (push),
      .push_entry (push_entry),
      .pop        (instr_ready),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (head)
   );

   assign instr_valid = ~fifo_empty;
   assign instr_data  = head.instr;
   assign instr_pc    = head.pc;
   assign instr_fault = head.fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected decode entries are queued as
// responses are driven and compared when decode pops them.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_current = '0;
   logic        fetch_req = 1'b0;
   logic        flush = 1'b0;
   logic        pc_accept;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_fault;
   logic        instr_ready = 1'b0;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
      logic        fault;
   } exp_t;

   exp_t expQ[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   grantCount = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && imem_req && imem_gnt) grantCount++;
   end

   instr_fetch #(
      .FIFO_DEPTH (2),
      .NOP_INSTR  (32'h0000_0013)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_current  (pc_current),
      .fetch_req   (fetch_req),
      .flush       (flush),
      .pc_accept   (pc_accept),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .instr_pc    (instr_pc),
      .instr_fault (instr_fault),
      .instr_ready (instr_ready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, wanted %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pc_accept"}, pc_accept, 0);
      checkOutput({tag, "_imem_req"}, imem_req, 0);
      checkOutput({tag, "_imem_addr"}, imem_addr, 0);
      checkOutput({tag, "_instr_valid"}, instr_valid, 0);
      checkOutput({tag, "_instr_data"}, instr_data, 0);
      checkOutput({tag, "_instr_pc"}, instr_pc, 0);
      checkOutput({tag, "_instr_fault"}, instr_fault, 0);
   endtask

   task automatic checkHead;
      exp_t e;
      checkOutput("sb_has_entry", 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
         checkOutput("head_valid", instr_valid, 1);
         checkOutput("head_data", instr_data, e.data);
         checkOutput("head_pc", instr_pc, e.pc);
         checkOutput("head_fault", instr_fault, e.fault);
      end
   endtask

   task automatic drainOne;
      checkHead();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic launchFetch(input logic [31:0] pc);
      pc_current = pc;
      fetch_req  = 1'b1;
      #1;
      checkOutput("pc_accept", pc_accept, 1);
      tick();
      fetch_req = 1'b0;
      #1;
      checkOutput("pc_accept_pulse", pc_accept, 0);
   endtask

   task automatic grantFetch(input logic [31:0] pc, input int delay);
      int g0;
      g0 = grantCount;
      imem_gnt = 1'b0;
      for (int i = 0; i < delay; i++) begin
         checkOutput("req_held", imem_req, 1);
         checkOutput("addr_held", imem_addr, pc);
         tick();
      end
      imem_gnt = 1'b1;
      checkOutput("req_at_gnt", imem_req, 1);
      checkOutput("addr_at_gnt", imem_addr, pc);
      tick();
      imem_gnt = 1'b0;
      checkOutput("req_drop", imem_req, 0);
      checkOutput("single_grant", grantCount - g0, 1);
   endtask

   task automatic respond(input logic [31:0] rdata, input logic [31:0] pc, input bit popHead);
      exp_t e;
      if (popHead) begin
         checkHead();
         instr_ready = 1'b1;
      end
      imem_rvalid = 1'b1;
      imem_rdata  = rdata;
      e.data = rdata;
      e.pc = pc;
      e.fault = 1'b0;
      expQ.push_back(e);
      tick();
      imem_rvalid = 1'b0;
      instr_ready = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] pc, input int delay, input logic [31:0] rdata,
                                input bit popHead = 1'b0);
      exp_t e;
      logic [1:0] low;
      low = pc[1:0];
      if (low != 2'b00) begin
         e.data = 32'h0000_0013;
         e.pc = pc;
         e.fault = 1'b1;
         expQ.push_back(e);
         launchFetch(pc);
         checkOutput("misaligned_no_req", imem_req, 0);
         checkOutput("misaligned_valid", instr_valid, 1);
      end else begin
         launchFetch(pc);
         grantFetch(pc, delay);
         respond(rdata, pc, popHead);
         checkOutput("fetch_latency", instr_valid, 1);
      end
   endtask

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      #3 rst_n = 1'b1;
      tick();

      // Basic aligned fetch
      applyStimulus(32'h0000_0004, 0, 32'h0050_0093);
      drainOne();
      checkOutput("empty_after_pop", instr_valid, 0);

      // Misaligned PC yields a fault NOP with no memory access
      applyStimulus(32'h0000_0006, 0, 32'h0);
      drainOne();

      // Back-pressure: two entries fill the buffer, third launch blocked
      applyStimulus(32'h0000_0000, 0, 32'h1111_1111);
      applyStimulus(32'h0000_0004, 1, 32'h2222_2222);
      pc_current = 32'h0000_0008;
      fetch_req  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checkOutput("blocked_accept", pc_accept, 0);
         checkOutput("blocked_req", imem_req, 0);
         tick();
      end
      drainOne();
      fetch_req = 1'b0;
      applyStimulus(32'h0000_0008, 0, 32'h3333_3333, 1'b1);
      drainOne();
      checkOutput("bp_empty", instr_valid, 0);

      // Flush in WAIT empties the buffer and drops the response
      applyStimulus(32'h0000_000A, 0, 32'h0);
      launchFetch(32'h0000_0010);
      grantFetch(32'h0000_0010, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      expQ.delete();
      checkOutput("flush_empties", instr_valid, 0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      checkOutput("discard_drop", instr_valid, 0);
      applyStimulus(32'h0000_0100, 0, 32'h0010_0113);
      drainOne();

      // Flush while the request is ungranted: request held, response dropped
      launchFetch(32'h0000_0040);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("req_held_after_flush", imem_req, 1);
      checkOutput("addr_held_after_flush", imem_addr, 32'h0000_0040);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1234_5678;
      tick();
      imem_rvalid = 1'b0;
      checkOutput("req_flush_drop", instr_valid, 0);
      applyStimulus(32'h0000_0044, 0, 32'h0020_0193);
      drainOne();

      // Delayed grant keeps request and address stable
      applyStimulus(32'h8000_0000, 3, 32'h00A0_0113);
      drainOne();

      // Reset during WAIT abandons the access; late response ignored
      applyStimulus(32'h0000_0003, 0, 32'h0);
      launchFetch(32'h0000_0020);
      grantFetch(32'h0000_0020, 0);
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      expQ.delete();
      #3 rst_n = 1'b1;
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
      tick();
      imem_rvalid = 1'b0;
      checkOutput("late_rvalid_ignored", instr_valid, 0);
      checkOutput("late_rvalid_no_req", imem_req, 0);
      applyStimulus(32'h0000_0030, 0, 32'h0030_0213);
      drainOne();

      checkOutput("sb_drained", expQ.size(), 0);
      checkOutput("final_empty", instr_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
